// File: rtl/cic_pkg.sv
// Shared constants and helpers for the PDM CIC decimator: accumulator sizing,
// bipolar PDM mapping and output word scaling.
package cic_pkg;

    localparam int unsigned MIN_STAGES = 1;
    localparam int unsigned MAX_STAGES = 6;
    localparam int unsigned MIN_DELAY  = 1;
    localparam int unsigned MAX_DELAY  = 2;

    // Wide enough for any legal accumulator before it is cut to the output width.
    localparam int unsigned SCALE_W = 128;

    localparam logic signed [1:0] PDM_POS = 2'sb01;
    localparam logic signed [1:0] PDM_NEG = 2'sb11;

    function automatic int unsigned acc_width(input int unsigned n_stages,
                                              input int unsigned dec_w,
                                              input int unsigned diff_delay);
        return n_stages * (dec_w + $clog2(diff_delay)) + 2;
    endfunction

    // acc_sx is the accumulator already sign-extended to SCALE_W bits; the
    // caller keeps the low out_w bits of the result.
    function automatic logic [SCALE_W-1:0] scale_word(input logic [SCALE_W-1:0] acc_sx,
                                                      input int unsigned        acc_w,
                                                      input int unsigned        out_w);
        logic signed [SCALE_W-1:0] acc_s;
        acc_s = signed'(acc_sx);
        if (acc_w <= out_w) begin
            return acc_sx;
        end
        return SCALE_W'(acc_s >>> (acc_w - out_w));
    endfunction

endpackage

// File: rtl/cic_chain.sv
// One CIC channel: N cascaded integrators at the mic bit rate feeding an
// N-stage comb pipeline that runs once per decimation strobe.
module cic_chain
    import cic_pkg::*;
#(
    parameter int unsigned N_STAGES   = 3,
    parameter int unsigned DIFF_DELAY = 1,
    parameter int unsigned ACC_W      = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic             pdm_bit,
    input  logic             strobe,
    output logic [ACC_W-1:0] word,
    output logic             word_valid
);

    if (N_STAGES < MIN_STAGES || N_STAGES > MAX_STAGES) begin : g_bad_stages
        $error("cic_chain: N_STAGES out of range");
    end
    if (DIFF_DELAY < MIN_DELAY || DIFF_DELAY > MAX_DELAY) begin : g_bad_delay
        $error("cic_chain: DIFF_DELAY out of range");
    end

    logic signed [1:0]   pdm_val;
    logic [ACC_W-1:0]    x_ext;
    logic [ACC_W-1:0]    integ   [N_STAGES];
    logic [ACC_W-1:0]    comb    [N_STAGES];
    logic [ACC_W-1:0]    comb_in [N_STAGES];
    logic [ACC_W-1:0]    dly     [N_STAGES][DIFF_DELAY];
    logic [N_STAGES-1:0] comb_en;
    logic [N_STAGES-1:0] comb_vld;

    assign pdm_val = pdm_bit ? PDM_POS : PDM_NEG;
    assign x_ext   = {{(ACC_W-2){pdm_val[1]}}, pdm_val};

    // Integrators wrap modulo 2^ACC_W; the combs undo the wrap exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < N_STAGES; k++) begin
                integ[k] <= '0;
            end
        end else if (sample_en) begin
            integ[0] <= integ[0] + x_ext;
            for (int unsigned k = 1; k < N_STAGES; k++) begin
                integ[k] <= integ[k] + integ[k-1];
            end
        end
    end

    always_comb begin
        comb_in[0] = integ[N_STAGES-1];
        comb_en[0] = strobe;
        for (int unsigned k = 1; k < N_STAGES; k++) begin
            comb_in[k] = comb[k-1];
            comb_en[k] = comb_vld[k-1];
        end
    end

    // The comb pipeline advances one stage per clk behind the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            comb_vld <= '0;
            for (int unsigned k = 0; k < N_STAGES; k++) begin
                comb[k] <= '0;
                for (int unsigned d = 0; d < DIFF_DELAY; d++) begin
                    dly[k][d] <= '0;
                end
            end
        end else begin
            for (int unsigned k = 0; k < N_STAGES; k++) begin
                comb_vld[k] <= comb_en[k];
                if (comb_en[k]) begin
                    comb[k]   <= comb_in[k] - dly[k][DIFF_DELAY-1];
                    dly[k][0] <= comb_in[k];
                    for (int unsigned d = 1; d < DIFF_DELAY; d++) begin
                        dly[k][d] <= dly[k][d-1];
                    end
                end
            end
        end
    end

    assign word       = comb[N_STAGES-1];
    assign word_valid = comb_vld[N_STAGES-1];

endmodule

// File: rtl/cic_pdm_decimator.sv
// PDM microphone CIC decimator: mic clock generation, decimation control and
// output sequencing. Define CIC_STEREO_EN to add a left channel sampled on rise events.
module cic_pdm_decimator
    import cic_pkg::*;
#(
    parameter int unsigned N_STAGES   = 3,
    parameter int unsigned DIFF_DELAY = 1,
    parameter int unsigned DEC_W      = 8,
    parameter int unsigned CLK_DIV_W  = 5,
    parameter int unsigned OUT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CLK_DIV_W-1:0] clk_div,
    input  logic [DEC_W-1:0]     dec_num,
    input  logic                 data_in,
    output logic                 clk_out,
    output logic                 channel,
    output logic [OUT_W-1:0]     data_out,
    output logic                 data_out_ch,
    output logic                 data_out_valid
);

    localparam int unsigned ACC_W = acc_width(N_STAGES, DEC_W, DIFF_DELAY);

    logic [CLK_DIV_W-1:0] div_cnt;
    logic                 tc;
    logic                 fall_ev;
    logic                 strobe;
    logic [DEC_W-1:0]     dec_cntr;
    logic [DEC_W-1:0]     dec_ratio;
    logic [ACC_W-1:0]     r_word;
    logic                 r_valid;

    function automatic logic [OUT_W-1:0] to_out(input logic [ACC_W-1:0] w);
        logic [SCALE_W-1:0] s;
        s = scale_word(SCALE_W'(signed'(w)), ACC_W, OUT_W);
        return s[OUT_W-1:0];
    endfunction

    assign channel = 1'b1;

    // Terminal count sits at div_cnt==0 so clk_out toggles on the first clk out of reset.
    assign tc      = (div_cnt == '0);
    assign fall_ev = tc & clk_out;
    assign strobe  = fall_ev & (dec_cntr == dec_ratio);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            clk_out <= 1'b1;
        end else begin
            div_cnt <= (div_cnt >= clk_div) ? '0 : div_cnt + CLK_DIV_W'(1);
            if (tc) begin
                clk_out <= ~clk_out;
            end
        end
    end

    // dec_ratio follows dec_num throughout reset and is re-sampled only on wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_cntr  <= '0;
            dec_ratio <= dec_num;
        end else if (strobe) begin
            dec_cntr  <= '0;
            dec_ratio <= dec_num;
        end else if (fall_ev) begin
            dec_cntr <= dec_cntr + DEC_W'(1);
        end
    end

    cic_chain #(
        .N_STAGES   (N_STAGES),
        .DIFF_DELAY (DIFF_DELAY),
        .ACC_W      (ACC_W)
    ) u_right (
        .clk        (clk),
        .rst        (rst),
        .sample_en  (fall_ev),
        .pdm_bit    (data_in),
        .strobe     (strobe),
        .word       (r_word),
        .word_valid (r_valid)
    );

`ifdef CIC_STEREO_EN
    logic             rise_ev;
    logic [ACC_W-1:0] l_word;
    logic             l_valid;
    logic [OUT_W-1:0] left_hold;
    logic             left_pending;

    assign rise_ev = tc & ~clk_out;

    cic_chain #(
        .N_STAGES   (N_STAGES),
        .DIFF_DELAY (DIFF_DELAY),
        .ACC_W      (ACC_W)
    ) u_left (
        .clk        (clk),
        .rst        (rst),
        .sample_en  (rise_ev),
        .pdm_bit    (data_in),
        .strobe     (strobe),
        .word       (l_word),
        .word_valid (l_valid)
    );

    // Both chains finish together; the left word waits one clk behind the right.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out       <= '0;
            data_out_ch    <= 1'b1;
            data_out_valid <= 1'b0;
            left_hold      <= '0;
            left_pending   <= 1'b0;
        end else begin
            data_out_valid <= 1'b0;
            if (r_valid) begin
                data_out       <= to_out(r_word);
                data_out_ch    <= 1'b1;
                data_out_valid <= 1'b1;
            end else if (left_pending) begin
                data_out       <= left_hold;
                data_out_ch    <= 1'b0;
                data_out_valid <= 1'b1;
            end
            left_pending <= l_valid;
            if (l_valid) begin
                left_hold <= to_out(l_word);
            end
        end
    end
`else
    assign data_out_ch = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            data_out_valid <= r_valid;
            if (r_valid) begin
                data_out <= to_out(r_word);
            end
        end
    end
`endif

endmodule

// File: tb/tb_cic_pdm_decimator.sv
// Randomised self-checking bench for cic_pdm_decimator against a sample-level
// CIC reference (cumulative sums, decimated snapshots, binomial comb formula).
module tb_cic_pdm_decimator;

    localparam int N  = 3;
    localparam int M  = 1;
    localparam int AW = 26;   // N*(DEC_W + clog2(M)) + 2 with DEC_W = 8

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  clk_div = 5'd4;
    logic [7:0]  dec_num = 8'd7;
    logic        data_in = 1'b0;
    logic        clk_out;
    logic        channel;
    logic [31:0] data_out;
    logic        data_out_ch;
    logic        data_out_valid;

    always #5 clk = ~clk;

    cic_pdm_decimator #(
        .N_STAGES   (N),
        .DIFF_DELAY (M),
        .DEC_W      (8),
        .CLK_DIV_W  (5),
        .OUT_W      (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .clk_div        (clk_div),
        .dec_num        (dec_num),
        .data_in        (data_in),
        .clk_out        (clk_out),
        .channel        (channel),
        .data_out       (data_out),
        .data_out_ch    (data_out_ch),
        .data_out_valid (data_out_valid)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)",
                      tag, $signed(got), got, $signed(expv), expv);
    endtask

    typedef struct {
        longint      at;
        logic [31:0] v;
        logic        ch;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] ir[N];
    logic [AW-1:0] il[N];
    logic [AW-1:0] sr[$];
    logic [AW-1:0] sl[$];
    longint        cyc = 0;
    int            rel, P, ratio, dcnt, alt_ph, n_strobes;
    logic          m_clk;
    longint        last_r_at, r_interval;
    logic [31:0]   last_r, last_l;

    function automatic int binom(input int n, input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    // y[j] = sum_i (-1)^i C(N,i) s[j - i*M], earlier snapshots taken as 0.
    function automatic logic [AW-1:0] comb_out(input bit left);
        logic [AW-1:0] acc;
        int            j;
        acc = '0;
        j = left ? sl.size() - 1 : sr.size() - 1;
        for (int i = 0; i <= N; i++) begin
            int            idx;
            logic [AW-1:0] s, term;
            idx = j - i * M;
            if (idx >= 0) begin
                s = left ? sl[idx] : sr[idx];
                term = AW'(binom(N, i)) * s;
                if (i % 2 == 1) acc = acc - term;
                else            acc = acc + term;
            end
        end
        return acc;
    endfunction

    function automatic logic [31:0] sx(input logic [AW-1:0] y);
        return {{(32-AW){y[AW-1]}}, y};
    endfunction

    task automatic integrate(input bit left, input logic din);
        for (int k = N - 1; k >= 1; k--) begin
            if (left) il[k] = il[k] + il[k-1];
            else      ir[k] = ir[k] + ir[k-1];
        end
        if (left) il[0] = il[0] + (din ? AW'(1) : '1);
        else      ir[0] = ir[0] + (din ? AW'(1) : '1);
    endtask

    task automatic snapshot();
        exp_t e;
        sr.push_back(ir[N-1]);
        e.at = cyc + N; e.v = sx(comb_out(1'b0)); e.ch = 1'b1;
        exp_q.push_back(e);
`ifdef CIC_STEREO_EN
        sl.push_back(il[N-1]);
        e.at = cyc + N + 1; e.v = sx(comb_out(1'b1)); e.ch = 1'b0;
        exp_q.push_back(e);
`endif
        n_strobes++;
    endtask

    task automatic model_reset();
        rel = 0; dcnt = 0; ratio = int'(dec_num); m_clk = 1'b1;
        for (int k = 0; k < N; k++) begin ir[k] = '0; il[k] = '0; end
        sr.delete(); sl.delete(); exp_q.delete();
    endtask

    task automatic step(input logic rst_v, input logic din);
        bit   fall, rise;
        exp_t e;
        @(negedge clk);
        rst = rst_v; data_in = din;
        @(posedge clk);
        cyc++;
        if (rst_v) model_reset();
        else begin
            fall = (rel % (2 * P)) == 0;
            rise = (rel % (2 * P)) == P;
            if (fall) begin
                if (dcnt == ratio) begin
                    snapshot();
                    dcnt = 0;
                    ratio = int'(dec_num);
                end else dcnt++;
                integrate(1'b0, din);
            end
            if (rise) integrate(1'b1, din);
            m_clk = ((rel / P) % 2) == 1;
            rel++;
        end
        #1;
        if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
            e = exp_q.pop_front();
            check("valid pulse", 32'(data_out_valid), 32'd1);
            check(e.ch ? "right word" : "left word", data_out, e.v);
            check("word channel", 32'(data_out_ch), 32'(e.ch));
        end else begin
            check("valid idle", 32'(data_out_valid), 32'd0);
        end
        check("clk_out", 32'(clk_out), 32'(m_clk));
        check("channel pin", 32'(channel), 32'd1);
        if (rst_v) begin
            check("data_out in reset", data_out, 32'd0);
            check("data_out_ch in reset", 32'(data_out_ch), 32'd1);
        end
        if (data_out_valid === 1'b1 && data_out_ch === 1'b1) begin
            if (last_r_at >= 0) r_interval = cyc - last_r_at;
            last_r_at = cyc;
            last_r = data_out;
        end
        if (data_out_valid === 1'b1 && data_out_ch === 1'b0) last_l = data_out;
    endtask

    task automatic do_reset(input int cd, input int dn);
        clk_div = 5'(cd);
        dec_num = 8'(dn);
        P = cd + 1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        last_r_at = -1; r_interval = 0; alt_ph = 0;
        last_r = 32'hDEAD_BEEF; last_l = 32'hDEAD_BEEF;
    endtask

    // mode: 0 right ones/left zeros, 1 alternating, 2 right zeros/left ones, 3 random
    task automatic run(input int cycles, input int mode);
        for (int i = 0; i < cycles; i++) begin
            logic b;
            b = 1'($urandom);
            if ((rel % (2 * P)) == 0) begin
                case (mode)
                    0: b = 1'b1;
                    1: begin b = alt_ph[0]; alt_ph ^= 1; end
                    2: b = 1'b0;
                    default: b = 1'($urandom);
                endcase
            end else if ((rel % (2 * P)) == P) begin
                case (mode)
                    0: b = 1'b0;
                    2: b = 1'b1;
                    default: b = 1'($urandom);
                endcase
            end
            step(1'b0, b);
        end
    endtask

    initial begin
        do_reset(4, 7);

        run(80 * 12, 0);
        check("dc ones R=8", last_r, 32'd512);
        check("interval R=8", 32'(r_interval), 32'd80);
`ifdef CIC_STEREO_EN
        check("dc left zeros R=8", last_l, 32'hFFFF_FE00);
`endif

        do_reset(4, 7);
        run(80 * 10, 1);
        check("alternating zero mean", last_r, 32'd0);

        do_reset(4, 7);
        run(80 * 10, 2);
        check("dc zeros R=8", last_r, 32'hFFFF_FE00);

        do_reset(4, 7);
        run(80 * 6 + 30, 0);
        dec_num = 8'd15;
        run(160 * 8, 0);
        check("dc ones R=16", last_r, 32'd4096);
        check("interval R=16", 32'(r_interval), 32'd160);

        do_reset(2, 3);
        n_strobes = 0;
        for (int i = 0; i < 2000 && n_strobes < 3; i++) run(1, 3);
        check("strobe seen before timeout", 32'(n_strobes >= 3), 32'd1);
        run(2, 3);
        for (int i = 0; i < N + 3; i++) step(1'b1, 1'b0);
        last_r_at = -1;
        run(300, 3);

        for (int t = 0; t < 6; t++) begin
            int cd, dn;
            cd = int'($urandom_range(0, 6));
            dn = int'($urandom_range(0, 19));
            do_reset(cd, dn);
            run(2 * (cd + 1) * (dn + 1) * 10 + 20, 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
